div_clk_monitor: RTL

- Receive-side checker for the clock-divider family (divide-by-3, divide-by-5 and similar).
- Samples a divided-clock output on the same system clock, measures its period and high time between rising edges, and declares lock after a run of good periods.
- Flags period, duty and timeout errors.
- Sits beside each divider instance, in the bench and in silicon self-test, as the consumer of the divider output q.

---
 rtl/div_mon_pkg.sv | 20 ++
 rtl/div_edge_det.sv | 23 ++
 rtl/div_clk_monitor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/div_mon_pkg.sv
// Shared types, defaults and the good-period rule for the divided-clock monitor family.
package div_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } mon_state_t;

  localparam int unsigned DEF_CW       = 8;
  localparam int unsigned DEF_LOCK_CNT = 4;

  // Accept high time of floor(n/2)..ceil(n/2) so dual-edge dividers with a half-cycle duty still pass.
  function automatic logic good_period(input int unsigned period,
                                       input int unsigned high,
                                       input int unsigned n);
    return (period == n) && (high >= n / 2) && (high <= (n + 1) / 2);
  endfunction

endpackage

// File: rtl/div_edge_det.sv
// One-register edge detector for a signal already in the clk domain.
module div_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig;
    end
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock sampled on clk, tracks lock
// against the expected ratio N and reports period, duty and timeout faults.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned CW       = DEF_CW,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned TMO      = 2 * N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_in,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          meas_valid,
  output logic          lock,
  output logic          err,
  output logic [7:0]    err_cnt
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  mon_state_t    state, state_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [CW-1:0] cnt, hcnt;
  logic [CW-1:0] meas_period;
  logic [CW-1:0] period_nxt, high_nxt;
  logic [7:0]    err_cnt_nxt;
  logic          lock_nxt, err_nxt, mv_nxt;
  logic          rise, fall_unused;
  logic          good, fault;

  // The falling edge is not needed by this checker.
  div_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (div_in),
    .rise (rise),
    .fall (fall_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= '0;
      hcnt <= CW'(1);
    end else begin
      if (!(&cnt)) cnt <= cnt + CW'(1);
      if (div_in && !(&hcnt)) hcnt <= hcnt + CW'(1);
    end
  end

  assign meas_period = (&cnt) ? cnt : cnt + CW'(1);
  assign good        = good_period(32'(meas_period), 32'(hcnt), N);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      period_o   <= '0;
      high_o     <= '0;
      meas_valid <= 1'b0;
      lock       <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      period_o   <= period_nxt;
      high_o     <= high_nxt;
      meas_valid <= mv_nxt;
      lock       <= lock_nxt;
      err        <= err_nxt;
      err_cnt    <= err_cnt_nxt;
    end
  end

  // A rise in the timeout cycle takes priority, so the timeout sits in the else branch.
  always_comb begin
    state_nxt   = state;
    good_nxt    = good_cnt;
    period_nxt  = period_o;
    high_nxt    = high_o;
    mv_nxt      = 1'b0;
    lock_nxt    = lock;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    fault       = 1'b0;

    unique case (state)
      SEARCH: begin
        if (rise) begin
          state_nxt = TRACK;
          good_nxt  = '0;
        end
      end
      TRACK, LOCKED: begin
        if (rise) begin
          mv_nxt     = 1'b1;
          period_nxt = meas_period;
          high_nxt   = hcnt;
          if (good) begin
            if (state == TRACK) begin
              if (good_cnt == GW'(LOCK_CNT - 1)) begin
                state_nxt = LOCKED;
                lock_nxt  = 1'b1;
                good_nxt  = GW'(LOCK_CNT);
              end else begin
                good_nxt = good_cnt + GW'(1);
              end
            end
          end else begin
            fault     = 1'b1;
            lock_nxt  = 1'b0;
            good_nxt  = '0;
            state_nxt = TRACK;
          end
        end else if (cnt == CW'(TMO - 1)) begin
          fault     = 1'b1;
          lock_nxt  = 1'b0;
          good_nxt  = '0;
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase

    if (fault) begin
      err_nxt = 1'b1;
      if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
    end
  end

endmodule
